// File: rtl/instruction_decoder.sv
// ---------------------------------------------------------------------------
// instruction_decoder
//
// Captures a 16-bit instruction word into an instruction register (IR) and,
// on request, decodes it into registered opcode / register-select / immediate
// outputs. A small Gray-coded FSM tracks whether the IR holds an undecoded
// word. It also flags handshake-ordering mistakes with a one-cycle seq_err
// pulse.
//
// Ports
//   clock       : rising-edge clock
//   reset       : synchronous, active-low reset
//   data_in     : instruction word from the data bus
//   inst_wr     : capture data_in into the IR
//   decoder_en  : decode the IR into the output registers (1-cycle latency)
//   opcode      : IR[15:12] of the last decoded word
//   rD_sel      : IR[11:9] of the last decoded word
//   rA_sel      : IR[8:6]  of the last decoded word
//   rB_sel      : IR[5:3]  of the last decoded word
//   imm         : decoded immediate of the last decoded word
//   flag        : last decoded opcode equals ILLEGAL_OP
//   valid       : decoded outputs correspond to the current IR
//   seq_err     : one-cycle pulse on a handshake-ordering violation
// ---------------------------------------------------------------------------
module instruction_decoder #(
    parameter logic [3:0] ILLEGAL_OP = 4'b1011
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] data_in,
    input  logic        inst_wr,
    input  logic        decoder_en,
    output logic [3:0]  opcode,
    output logic [2:0]  rD_sel,
    output logic [2:0]  rA_sel,
    output logic [2:0]  rB_sel,
    output logic [15:0] imm,
    output logic        flag,
    output logic        valid,
    output logic        seq_err
);

    localparam logic [3:0] OP_LOAD = 4'b0011;
    localparam logic [3:0] OP_JUMP = 4'b0101;

    // Gray-coded so that every legal transition flips a single bit.
    typedef enum logic [1:0] {
        EMPTY   = 2'b00,
        LOADED  = 2'b01,
        DECODED = 2'b11
    } state_t;

    state_t      state_q,   state_d;
    logic [15:0] ir_q,      ir_d;
    logic [3:0]  opcode_q,  opcode_d;
    logic [2:0]  rd_sel_q,  rd_sel_d;
    logic [2:0]  ra_sel_q,  ra_sel_d;
    logic [2:0]  rb_sel_q,  rb_sel_d;
    logic [15:0] imm_q,     imm_d;
    logic        flag_q,    flag_d;
    logic        seq_err_q, seq_err_d;

    // Immediate decode of the current IR contents.
    logic [15:0] imm_dec;

    always_comb begin
        imm_dec = 16'h0000;
        case (ir_q[15:12])
            OP_LOAD: imm_dec = ir_q[8] ? {ir_q[7:0], 8'h00} : {8'h00, ir_q[7:0]};
            OP_JUMP: imm_dec = {4'h0, ir_q[11:0]};
            default: imm_dec = 16'h0000;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        opcode_d  = opcode_q;
        rd_sel_d  = rd_sel_q;
        ra_sel_d  = ra_sel_q;
        rb_sel_d  = rb_sel_q;
        imm_d     = imm_q;
        flag_d    = flag_q;
        seq_err_d = 1'b0;

        if (inst_wr) begin
            // A write always wins over a simultaneous decode request; the
            // decoded outputs keep describing the previous word.
            ir_d      = data_in;
            state_d   = LOADED;
            seq_err_d = decoder_en || (state_q == LOADED);
        end else if (decoder_en) begin
            if (state_q == EMPTY) begin
                // Nothing to decode: report it and leave outputs alone.
                seq_err_d = 1'b1;
            end else begin
                // Re-decoding in DECODED reproduces identical outputs.
                opcode_d = ir_q[15:12];
                rd_sel_d = ir_q[11:9];
                ra_sel_d = ir_q[8:6];
                rb_sel_d = ir_q[5:3];
                imm_d    = imm_dec;
                flag_d   = (ir_q[15:12] == ILLEGAL_OP);
                state_d  = DECODED;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= EMPTY;
            ir_q      <= 16'h0000;
            opcode_q  <= ILLEGAL_OP;
            rd_sel_q  <= 3'd0;
            ra_sel_q  <= 3'd0;
            rb_sel_q  <= 3'd0;
            imm_q     <= 16'h0000;
            flag_q    <= 1'b0;
            seq_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            opcode_q  <= opcode_d;
            rd_sel_q  <= rd_sel_d;
            ra_sel_q  <= ra_sel_d;
            rb_sel_q  <= rb_sel_d;
            imm_q     <= imm_d;
            flag_q    <= flag_d;
            seq_err_q <= seq_err_d;
        end
    end

    assign opcode  = opcode_q;
    assign rD_sel  = rd_sel_q;
    assign rA_sel  = ra_sel_q;
    assign rB_sel  = rb_sel_q;
    assign imm     = imm_q;
    assign flag    = flag_q;
    assign valid   = (state_q == DECODED);
    assign seq_err = seq_err_q;

endmodule

// File: tb/tb_instruction_decoder.sv
// ---------------------------------------------------------------------------
// tb_instruction_decoder
//
// Directed scoreboard bench. Each step drives one cycle of inputs on the
// falling edge and queues the hand-computed outputs expected after the next
// rising edge. The monitor samples 1 time unit after every rising edge and
// compares against the head of the queue.
// ---------------------------------------------------------------------------
module tb_instruction_decoder;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] data_in;
    logic        inst_wr;
    logic        decoder_en;
    logic [3:0]  opcode;
    logic [2:0]  rD_sel;
    logic [2:0]  rA_sel;
    logic [2:0]  rB_sel;
    logic [15:0] imm;
    logic        flag;
    logic        valid;
    logic        seq_err;

    instruction_decoder #(.ILLEGAL_OP(4'b1011)) dut (
        .clock      (clock),
        .reset      (reset),
        .data_in    (data_in),
        .inst_wr    (inst_wr),
        .decoder_en (decoder_en),
        .opcode     (opcode),
        .rD_sel     (rD_sel),
        .rA_sel     (rA_sel),
        .rB_sel     (rB_sel),
        .imm        (imm),
        .flag       (flag),
        .valid      (valid),
        .seq_err    (seq_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [2:0]  rd;
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic [15:0] imm;
        logic        flag;
        logic        valid;
        logic        se;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic step(input string name, input logic rst_n, input logic wr,
                        input logic de, input logic [15:0] data,
                        input logic [3:0] op, input logic [2:0] rd,
                        input logic [2:0] ra, input logic [2:0] rb,
                        input logic [15:0] im, input logic fl,
                        input logic vl, input logic se);
        exp_t e;
        @(negedge clock);
        reset      = rst_n;
        inst_wr    = wr;
        decoder_en = de;
        data_in    = data;
        e.name = name; e.op = op; e.rd = rd; e.ra = ra; e.rb = rb;
        e.imm = im; e.flag = fl; e.valid = vl; e.se = se;
        exp_q.push_back(e);
    endtask

    // Monitor: one comparison (and one line) per transaction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (opcode !== e.op || rD_sel !== e.rd || rA_sel !== e.ra ||
                    rB_sel !== e.rb || imm !== e.imm || flag !== e.flag ||
                    valid !== e.valid || seq_err !== e.se) begin
                    errors++;
                    $display("FAIL %s: got op=%h rd=%0d ra=%0d rb=%0d imm=%h flag=%b valid=%b seq_err=%b, want op=%h rd=%0d ra=%0d rb=%0d imm=%h flag=%b valid=%b seq_err=%b",
                             e.name, opcode, rD_sel, rA_sel, rB_sel, imm, flag, valid, seq_err,
                             e.op, e.rd, e.ra, e.rb, e.imm, e.flag, e.valid, e.se);
                end else begin
                    $display("ok   %s: op=%h rd=%0d ra=%0d rb=%0d imm=%h flag=%b valid=%b seq_err=%b",
                             e.name, opcode, rD_sel, rA_sel, rB_sel, imm, flag, valid, seq_err);
                end
            end
        end
    end

    initial begin
        int waited;
        reset = 1'b0; inst_wr = 1'b0; decoder_en = 1'b0; data_in = 16'h0000;

        //    name               rst wr de data       op    rd ra rb imm      fl vl se
        step("reset",            0, 0, 0, 16'h0000, 4'hB, 0, 0, 0, 16'h0000, 0, 0, 0);
        step("idle_after_reset", 1, 0, 0, 16'h0000, 4'hB, 0, 0, 0, 16'h0000, 0, 0, 0);
        step("dec_in_empty",     1, 0, 1, 16'h0000, 4'hB, 0, 0, 0, 16'h0000, 0, 0, 1);
        step("seq_err_one_cyc",  1, 0, 0, 16'h0000, 4'hB, 0, 0, 0, 16'h0000, 0, 0, 0);
        step("wr_0A98",          1, 1, 0, 16'h0A98, 4'hB, 0, 0, 0, 16'h0000, 0, 0, 0);
        step("dec_0A98",         1, 0, 1, 16'h0000, 4'h0, 5, 2, 3, 16'h0000, 0, 1, 0);
        step("redecode_0A98",    1, 0, 1, 16'h0000, 4'h0, 5, 2, 3, 16'h0000, 0, 1, 0);
        step("wr_31A5_hold",     1, 1, 0, 16'h31A5, 4'h0, 5, 2, 3, 16'h0000, 0, 0, 0);
        step("dec_load_hi",      1, 0, 1, 16'h0000, 4'h3, 0, 6, 4, 16'hA500, 0, 1, 0);
        step("wr_30A5_hold",     1, 1, 0, 16'h30A5, 4'h3, 0, 6, 4, 16'hA500, 0, 0, 0);
        step("dec_load_lo",      1, 0, 1, 16'h0000, 4'h3, 0, 2, 4, 16'h00A5, 0, 1, 0);
        step("wr_1234",          1, 1, 0, 16'h1234, 4'h3, 0, 2, 4, 16'h00A5, 0, 0, 0);
        step("overwrite_loaded", 1, 1, 0, 16'h5ABC, 4'h3, 0, 2, 4, 16'h00A5, 0, 0, 1);
        step("dec_jump",         1, 0, 1, 16'h0000, 4'h5, 5, 2, 7, 16'h0ABC, 0, 1, 0);
        step("wr_and_dec_dec",   1, 1, 1, 16'hB000, 4'h5, 5, 2, 7, 16'h0ABC, 0, 0, 1);
        step("dec_illegal",      1, 0, 1, 16'h0000, 4'hB, 0, 0, 0, 16'h0000, 1, 1, 0);
        step("wr_0A98_again",    1, 1, 0, 16'h0A98, 4'hB, 0, 0, 0, 16'h0000, 1, 0, 0);
        step("reset_beats_wr",   0, 1, 1, 16'h5ABC, 4'hB, 0, 0, 0, 16'h0000, 0, 0, 0);
        step("first_wr_30A5",    1, 1, 0, 16'h30A5, 4'hB, 0, 0, 0, 16'h0000, 0, 0, 0);
        step("dec_after_first",  1, 0, 1, 16'h0000, 4'h3, 0, 2, 4, 16'h00A5, 0, 1, 0);
        step("wr_1234_b",        1, 1, 0, 16'h1234, 4'h3, 0, 2, 4, 16'h00A5, 0, 0, 0);
        step("reset_in_loaded",  0, 0, 0, 16'h0000, 4'hB, 0, 0, 0, 16'h0000, 0, 0, 0);
        step("dec_after_rst",    1, 0, 1, 16'h0000, 4'hB, 0, 0, 0, 16'h0000, 0, 0, 1);
        step("wr_and_dec_empty", 1, 1, 1, 16'h5ABC, 4'hB, 0, 0, 0, 16'h0000, 0, 0, 1);
        step("dec_5ABC",         1, 0, 1, 16'h0000, 4'h5, 5, 2, 7, 16'h0ABC, 0, 1, 0);
        step("hold_idle",        1, 0, 0, 16'hFFFF, 4'h5, 5, 2, 7, 16'h0ABC, 0, 1, 0);

        @(negedge clock);
        inst_wr = 1'b0; decoder_en = 1'b0;

        waited = 0;
        while (exp_q.size() > 0 && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected transactions left, want 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
